key_input_conditioner: RTL

- Front-end stage placed directly upstream of calctop; the raw active-low pad inputs come from the board buttons.
- Synchronises, debounces and validates the 14 active-low calculator buttons: push[9:0], plus, minus, equal and ce.
- Emits exactly one single-cycle, registered event per accepted press.
- Rejects simultaneous multi-key presses.

---
 rtl/key_input_conditioner.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - synchronise, debounce and validate the 14 active-low calculator keys
// Emits one registered single-cycle event per accepted single-key press; multi-key presses lock out.
module key_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] push,
  input  logic       plus,
  input  logic       minus,
  input  logic       equal,
  input  logic       ce,
  output logic       digit_valid,
  output logic [3:0] digit,
  output logic       plus_pulse,
  output logic       minus_pulse,
  output logic       equal_pulse,
  output logic       ce_pulse,
  output logic       multi_lock
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    HELD     = 3'd2,
    RELEASE  = 3'd3,
    LOCK     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [13:0] raw;
  logic [13:0] sync1;
  logic [13:0] sync2;
  logic [13:0] pressed;
  logic [13:0] latched_hot;
  logic        any_key;
  logic        one_key;
  logic        many_keys;
  logic        match;
  logic [3:0]  enc_idx;

  state_t          state;
  state_t          state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]      key_idx;
  logic [3:0]      key_idx_n;
  logic            fire;

  logic       digit_valid_n;
  logic [3:0] digit_n;
  logic       plus_pulse_n;
  logic       minus_pulse_n;
  logic       equal_pulse_n;
  logic       ce_pulse_n;
  logic       multi_lock_n;

  assign raw = {ce, equal, minus, plus, push};

  // Released level is 1, so the synchroniser resets to "nothing pressed".
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign pressed     = ~sync2;
  assign any_key     = |pressed;
  assign one_key     = any_key && ((pressed & (pressed - 14'd1)) == 14'd0);
  assign many_keys   = any_key && !one_key;
  assign latched_hot = 14'd1 << key_idx;
  assign match       = (pressed == latched_hot);

  always_comb begin
    enc_idx = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (pressed[i]) begin
        enc_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      key_idx <= 4'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      key_idx <= key_idx_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    key_idx_n = key_idx;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (one_key) begin
          key_idx_n = enc_idx;
          cnt_n     = CNT_ONE;
          state_n   = DEBOUNCE;
        end else if (many_keys) begin
          cnt_n   = CNT_ONE;
          state_n = LOCK;
        end
      end
      DEBOUNCE: begin
        if (many_keys) begin
          cnt_n   = CNT_ONE;
          state_n = LOCK;
        end else if (match) begin
          if (cnt >= CNT_MAX) begin
            fire    = 1'b1;
            state_n = HELD;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      HELD: begin
        if (!any_key) begin
          cnt_n   = CNT_ONE;
          state_n = RELEASE;
        end
      end
      RELEASE, LOCK: begin
        // Any activity restarts the quiet-time count so release bounce cannot re-arm.
        if (any_key) begin
          cnt_n = CNT_ONE;
        end else if (cnt >= CNT_MAX) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    digit_valid_n = fire && (key_idx < 4'd10);
    plus_pulse_n  = fire && (key_idx == 4'd10);
    minus_pulse_n = fire && (key_idx == 4'd11);
    equal_pulse_n = fire && (key_idx == 4'd12);
    ce_pulse_n    = fire && (key_idx == 4'd13);
    digit_n       = digit_valid_n ? key_idx : digit;
    multi_lock_n  = (state_n == LOCK);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      digit_valid <= 1'b0;
      digit       <= 4'd0;
      plus_pulse  <= 1'b0;
      minus_pulse <= 1'b0;
      equal_pulse <= 1'b0;
      ce_pulse    <= 1'b0;
      multi_lock  <= 1'b0;
    end else begin
      digit_valid <= digit_valid_n;
      digit       <= digit_n;
      plus_pulse  <= plus_pulse_n;
      minus_pulse <= minus_pulse_n;
      equal_pulse <= equal_pulse_n;
      ce_pulse    <= ce_pulse_n;
      multi_lock  <= multi_lock_n;
    end
  end

endmodule
